vga_scan: RTL and testbench

//  Raster timing generator and video output stage for the 640x480@60 VGA path.

---
 rtl/vga_scan_pkg.sv | 33 +++
 rtl/vga_scan_pix_div.sv | 41 ++++
 rtl/vga_scan.sv | 114 +++++++++++
 tb/tb_vga_scan.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_scan_pkg.sv
// Shared VGA 640x480@60 timing defaults and helpers.
// Totals must stay at or below 1024 so they fit the 10-bit counters.
package vga_scan_pkg;

  localparam int CW = 10;

  localparam int CLK_DIV_DEF  = 2;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;

  localparam int H_TOTAL_DEF =
    H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
  localparam int V_TOTAL_DEF =
    V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;
  localparam int H_ACT_START_DEF = H_SYNC_DEF + H_BP_DEF;
  localparam int V_ACT_START_DEF = V_SYNC_DEF + V_BP_DEF;

  // Half-open window test: lo <= c < hi.
  function automatic logic in_win(
    input logic [CW-1:0] c,
    input logic [CW-1:0] lo,
    input logic [CW-1:0] hi
  );
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_scan_pix_div.sv
// Pixel-clock divider: one-sysclk pix_ce strobe every CLK_DIV cycles.
// pix_ce is registered so it reads 0 while reset is held.
module vga_pix_div
  import vga_scan_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic sysclk,
  input  logic rst_n,
  output logic pix_ce
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;
  logic          pix_ce_q;
  logic          pix_ce_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == DMAX) begin
      div_cnt_d = '0;
    end
    pix_ce_d = (div_cnt_d == DMAX);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pix_ce_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_ce_q  <= pix_ce_d;
    end
  end

  assign pix_ce = pix_ce_q;

endmodule

// File: rtl/vga_scan.sv
// Raster timing generator and registered video output stage.
// hsync, vsync and vga_rgb show the pixel at display_addr one tick late.
module vga_scan
  import vga_scan_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic [2:0]  display_data,
  output logic [19:0] display_addr,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  vga_rgb,
  output logic        pix_ce,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SW    = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SW    = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_S = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_ACT_E = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_S = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_ACT_E = CW'(V_SYNC + V_BP + V_ACTIVE);

  logic [CW-1:0] h_cnt_q;
  logic [CW-1:0] h_cnt_d;
  logic [CW-1:0] v_cnt_q;
  logic [CW-1:0] v_cnt_d;
  logic [2:0]    rgb_q;
  logic [2:0]    rgb_d;
  logic          hs_q;
  logic          hs_d;
  logic          vs_q;
  logic          vs_d;
  logic          fs_q;
  logic          fs_d;
  logic          act;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .pix_ce (pix_ce)
  );

  assign act = in_win(h_cnt_q, H_ACT_S, H_ACT_E)
            && in_win(v_cnt_q, V_ACT_S, V_ACT_E);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    rgb_d   = rgb_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    fs_d    = 1'b0;
    if (pix_ce) begin
      if (h_cnt_q == H_MAX) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_MAX) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      // Output stage samples the pixel currently addressed.
      rgb_d = act ? display_data : 3'b000;
      hs_d  = ~(h_cnt_q < H_SW);
      vs_d  = ~(v_cnt_q < V_SW);
      fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      rgb_q   <= 3'b000;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end

  assign display_addr = {h_cnt_q, v_cnt_q};
  assign hsync        = hs_q;
  assign vsync        = vs_q;
  assign vga_rgb      = rgb_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan with a shortened vertical raster.
// Vertical: sync 2, bp 3, active 4 (y 5..8), fp 2 -> 11 lines.
module tb_vga_scan;

  localparam int VT    = 11;
  localparam int LINE  = 800;
  localparam int FRAME = LINE * VT;
  localparam int BOUND = 4 * FRAME;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [2:0]  display_data = 3'b000;
  logic [19:0] display_addr;
  logic        hsync;
  logic        vsync;
  logic [2:0]  vga_rgb;
  logic        pix_ce;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] d;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t tbl[12];

  vga_scan #(
    .CLK_DIV  (2),
    .V_SYNC   (2),
    .V_BP     (3),
    .V_ACTIVE (4),
    .V_FP     (2)
  ) dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .display_data (display_data),
    .display_addr (display_addr),
    .hsync        (hsync),
    .vsync        (vsync),
    .vga_rgb      (vga_rgb),
    .pix_ce       (pix_ce),
    .frame_start  (frame_start)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Stop at the negedge where pix_ce is high and addr is (h,v).
  task automatic run_to(input logic [9:0] h, input logic [9:0] v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge sysclk);
      if (pix_ce && display_addr == {h, v}) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL run_to(%0d,%0d): timeout", h, v);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rgb"}, int'(vga_rgb), 0);
    chk({nm, "_hs"}, int'(hsync), 1);
    chk({nm, "_vs"}, int'(vsync), 1);
    chk({nm, "_addr"}, int'(display_addr), 0);
    chk({nm, "_ce"}, int'(pix_ce), 0);
    chk({nm, "_fs"}, int'(frame_start), 0);
  endtask

  // Release at a negedge, then follow the first two sysclk edges.
  task automatic release_and_check(input string nm);
    rst_n = 1'b1;
    @(negedge sysclk);
    chk({nm, "_ce1"}, int'(pix_ce), 1);
    chk({nm, "_addr1"}, int'(display_addr), 0);
    chk({nm, "_fs1"}, int'(frame_start), 0);
    @(negedge sysclk);
    chk({nm, "_ce2"}, int'(pix_ce), 0);
    chk({nm, "_addr2"}, int'(display_addr), 1 << 10);
    chk({nm, "_fs2"}, int'(frame_start), 1);
    chk({nm, "_hs2"}, int'(hsync), 0);
    @(negedge sysclk);
    chk({nm, "_fs3"}, int'(frame_start), 0);
  endtask

  initial begin
    int lo;
    int hi;
    int vlo;
    int fs_cyc;
    int fs_pulses;
    logic fs_prev;

    tbl[0]  = '{10'd0,   10'd0,  3'b101, 3'b000, 1'b0, 1'b0};
    tbl[1]  = '{10'd95,  10'd1,  3'b101, 3'b000, 1'b0, 1'b0};
    tbl[2]  = '{10'd96,  10'd2,  3'b101, 3'b000, 1'b1, 1'b1};
    tbl[3]  = '{10'd150, 10'd4,  3'b101, 3'b000, 1'b1, 1'b1};
    tbl[4]  = '{10'd143, 10'd5,  3'b101, 3'b000, 1'b1, 1'b1};
    tbl[5]  = '{10'd144, 10'd5,  3'b101, 3'b101, 1'b1, 1'b1};
    tbl[6]  = '{10'd783, 10'd5,  3'b101, 3'b101, 1'b1, 1'b1};
    tbl[7]  = '{10'd784, 10'd5,  3'b101, 3'b000, 1'b1, 1'b1};
    tbl[8]  = '{10'd300, 10'd6,  3'b011, 3'b011, 1'b1, 1'b1};
    tbl[9]  = '{10'd500, 10'd8,  3'b110, 3'b110, 1'b1, 1'b1};
    tbl[10] = '{10'd144, 10'd9,  3'b101, 3'b000, 1'b1, 1'b1};
    tbl[11] = '{10'd799, 10'd10, 3'b101, 3'b000, 1'b1, 1'b1};

    // Power-on reset
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk_reset_vals("por");
    release_and_check("por");

    // One line: wrap 799->0 with v 0->1, then hsync duty
    run_to(10'd799, 10'd0);
    @(negedge sysclk);
    @(negedge sysclk);
    chk("hwrap_addr", int'(display_addr), 1);
    lo = 0;
    hi = 0;
    for (int i = 0; i < LINE; i++) begin
      run_to(display_addr[19:10], display_addr[9:0]);
      @(negedge sysclk);
      if (hsync) hi++;
      else lo++;
    end
    chk("hs_low_ticks", lo, 96);
    chk("hs_high_ticks", hi, 704);

    // Table of pixels in scan order within one frame
    foreach (tbl[i]) begin
      run_to(tbl[i].h, tbl[i].v);
      display_data = tbl[i].d;
      @(negedge sysclk);
      chk($sformatf("vec%0d_rgb", i), int'(vga_rgb), int'(tbl[i].rgb));
      chk($sformatf("vec%0d_hs", i), int'(hsync), int'(tbl[i].hs));
      chk($sformatf("vec%0d_vs", i), int'(vsync), int'(tbl[i].vs));
    end

    // Whole frame: vsync duty and frame_start pulse
    vlo = 0;
    fs_cyc = 0;
    fs_pulses = 0;
    fs_prev = frame_start;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge sysclk);
      if (pix_ce && !vsync) vlo++;
      if (frame_start) fs_cyc++;
      if (frame_start && !fs_prev) fs_pulses++;
      fs_prev = frame_start;
    end
    chk("vs_low_ticks", vlo, 2 * LINE);
    chk("fs_pulses", fs_pulses, 1);
    chk("fs_cycles", fs_cyc, 1);

    // Mid-tick data changes must be ignored
    run_to(10'd200, 10'd5);
    display_data = 3'b010;
    @(negedge sysclk);
    chk("tog_load", int'(vga_rgb), 2);
    chk("tog_ce_low", int'(pix_ce), 0);
    display_data = 3'b111;
    @(negedge sysclk);
    chk("tog_hold", int'(vga_rgb), 2);
    display_data = 3'b001;
    @(negedge sysclk);
    chk("tog_next", int'(vga_rgb), 1);

    // Async reset in the active area
    run_to(10'd400, 10'd7);
    display_data = 3'b111;
    @(posedge sysclk);
    #1;
    chk("mid_rgb_pre", int'(vga_rgb), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    chk_reset_vals("held");
    release_and_check("rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
